bit_synchronizer: RTL and testbench

//   Multi-flop clock-domain-crossing synchronizer for a bus of independent

---
 rtl/bit_synchronizer.sv | 43 ++++
 tb/tb_bit_synchronizer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/bit_synchronizer.sv
// Per-bit multi-flop synchronizer for quasi-static level signals crossing into CLK.
// Every bit owns an independent NUM_STAGES-deep shift chain; SYNC is the last flop of each chain.
`timescale 1ns/1ps

module bit_synchronizer #(
  parameter int BUS_WIDTH  = 1,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC
);

  // A single flop gives no metastability settling time, so refuse to build one.
  generate
    if (NUM_STAGES < 2) begin : g_bad_stages
      $error("bit_synchronizer: NUM_STAGES must be >= 2");
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
      $error("bit_synchronizer: BUS_WIDTH must be >= 1");
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < BUS_WIDTH; i++) begin : g_bit
      logic [NUM_STAGES-1:0] chain;

      // Stage 0 captures the raw input; higher stages only see registered data.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          chain <= '0;
        end else begin
          chain <= {chain[NUM_STAGES-2:0], ASYNC[i]};
        end
      end

      assign SYNC[i] = chain[NUM_STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_bit_synchronizer.sv
// Directed bench for bit_synchronizer: two-stage and four-stage instances share one input bus
// and are checked every cycle against a sampled-history model plus literal expectations.
`timescale 1ns/1ps

module tb_bit_synchronizer;

  logic       clk;
  logic       rst;
  logic [2:0] async_in;
  logic [2:0] sync2;
  logic [2:0] sync4;

  int checks = 0;
  int errors = 0;
  bit model_en = 0;

  // Values of ASYNC seen at each rising edge since the last reset, oldest first.
  logic [2:0] hist[$];

  bit_synchronizer #(.BUS_WIDTH(3), .NUM_STAGES(2)) dut2 (
    .CLK(clk), .RST(rst), .ASYNC(async_in), .SYNC(sync2)
  );

  bit_synchronizer #(.BUS_WIDTH(3), .NUM_STAGES(4)) dut4 (
    .CLK(clk), .RST(rst), .ASYNC(async_in), .SYNC(sync4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
    end else begin
      hist.push_back(async_in);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  // Output after n edges is the input sampled n edges ago; zero until that many edges exist.
  function automatic logic [2:0] model_out(int n);
    if (hist.size() >= n) return hist[hist.size() - n];
    return 3'b000;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_en) begin
      chk("model_s2", sync2, model_out(2));
      chk("model_s4", sync4, model_out(4));
    end
  end

  initial begin
    rst      = 1'b1;
    async_in = 3'b000;

    // Reset takes effect with no clock edge.
    #4   rst = 1'b0;
    #0.5 chk("rst_noclk_s2", sync2, 3'b000);
    chk("rst_noclk_s4", sync4, 3'b000);

    #2.5 rst = 1'b1;
    async_in = 3'b101;
    model_en = 1;

    // Two-stage latency: nothing after edge 1, data after edge 2.
    @(posedge clk); #1 chk("lat_edge1_s2", sync2, 3'b000);
    @(posedge clk); #5 chk("lat_edge2_s2", sync2, 3'b101);

    // Value change 101 -> 010.
    async_in = 3'b010;
    @(posedge clk); #1 chk("hold_edge1_s2", sync2, 3'b101);
    @(posedge clk); #1 chk("new_edge2_s2", sync2, 3'b010);

    // Four-stage latency on a single-bit step.
    #3 async_in = 3'b000;
    repeat (5) @(posedge clk);
    #4 async_in = 3'b001;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("step_s4_e%0d", k), sync4, (k == 4) ? 3'b001 : 3'b000);
      chk($sformatf("step_s2_e%0d", k), sync2, (k >= 2) ? 3'b001 : 3'b000);
    end

    // Mid-stream reset clears outputs at once, then full latency to refill.
    #3 async_in = 3'b101;
    repeat (5) @(posedge clk);
    #2 chk("pre_rst_s2", sync2, 3'b101);
    chk("pre_rst_s4", sync4, 3'b101);
    rst = 1'b0;
    #1 chk("mid_rst_s2", sync2, 3'b000);
    chk("mid_rst_s4", sync4, 3'b000);
    #1 rst = 1'b1;
    @(posedge clk); #1 chk("refill_e1_s2", sync2, 3'b000);
    @(posedge clk); #1 chk("refill_e2_s2", sync2, 3'b101);
    @(posedge clk); #1 chk("refill_e3_s4", sync4, 3'b000);
    @(posedge clk); #1 chk("refill_e4_s4", sync4, 3'b101);

    // Glitch strictly between edges is never sampled.
    #2 async_in = 3'b000;
    repeat (5) @(posedge clk);
    #2 async_in = 3'b111;
    #4 async_in = 3'b000;
    repeat (3) begin
      @(posedge clk); #1;
      chk("glitch_s2", sync2, 3'b000);
      chk("glitch_s4", sync4, 3'b000);
    end

    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
